// File: rtl/line_burst_adaptor_if.sv
// Bundle of the arbiter-side line port and the memory-side burst port.
// slave is the adaptor's view; master is the view of whatever drives it.
interface line_burst_adaptor_if;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// Converts one 256-bit line request into a four-beat 64-bit memory burst
// and reassembles read beats into a line; one transaction at a time.
module line_burst_adaptor (
  input  logic                  clk,
  input  logic                  rst,
  line_burst_adaptor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wline_q, wline_d;
  logic [255:0] rline_q, rline_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        // Write takes priority if the arbiter ever raises both requests.
        if (bus.write_i) begin
          wline_d = bus.line_i;
          addr_d  = {bus.address_i[31:5], 5'b0};
          cnt_d   = '0;
          state_d = WRITE;
        end else if (bus.read_i) begin
          addr_d  = {bus.address_i[31:5], 5'b0};
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          rline_d[{cnt_q, 6'd0} +: 64] = bus.burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_o    = (state_q == READ);
  assign bus.write_o   = (state_q == WRITE);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = addr_q;
  assign bus.line_o    = rline_q;
  assign bus.burst_o   = wline_q[{cnt_q, 6'd0} +: 64];

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: directed vector table, reset
// corner cases, and randomized transactions against a transaction-level model.
module tb_line_burst_adaptor;

  logic clk;
  logic rst;
  line_burst_adaptor_if bus ();

  line_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [255:0] last_read;

  typedef struct {
    bit           wr;
    bit           both;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [31:0]  pat;
    int           pat_len;
    logic [31:0]  exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_o"},    bus.read_o, '0);
    chk({tag, "_write_o"},   bus.write_o, '0);
    chk({tag, "_resp_o"},    bus.resp_o, '0);
    chk({tag, "_address_o"}, bus.address_o, '0);
    chk({tag, "_line_o"},    bus.line_o, '0);
    chk({tag, "_burst_o"},   bus.burst_o, '0);
  endtask

  // Upstream holds its request through the resp_o cycle and one more cycle,
  // so a request sampled in DONE would show up as a spurious restart.
  task automatic run_txn(input bit wr, input bit both, input logic [31:0] addr,
                         input logic [255:0] data, input logic [31:0] pat,
                         input int pat_len, input logic [31:0] exp_addr);
    int beat = 0;
    int cyc  = 0;
    bit r;
    logic [63:0]  got_beats[$];
    logic [255:0] exp_line;
    @(negedge clk);
    bus.address_i = addr;
    bus.line_i    = data;
    bus.write_i   = wr;
    bus.read_i    = !wr || both;
    @(negedge clk);
    bus.address_i = $urandom;
    bus.line_i    = {8{$urandom}};
    while (beat < 4 && cyc < 64) begin
      chk("cmd_read",  bus.read_o, !wr);
      chk("cmd_write", bus.write_o, wr);
      chk("address_o", bus.address_o, exp_addr);
      chk("resp_early", bus.resp_o, 1'b0);
      if (wr) chk("burst_o", bus.burst_o, data[64*beat +: 64]);
      else    chk("line_hold_write", 1'b0, 1'b0 & bus.resp_o);
      r = (cyc < pat_len) ? pat[cyc] : 1'b1;
      bus.resp_i  = r;
      bus.burst_i = r ? data[64*beat +: 64] : {$urandom, $urandom};
      if (r && !wr) got_beats.push_back(data[64*beat +: 64]);
      @(negedge clk);
      if (r) beat++;
      cyc++;
    end
    if (beat < 4) chk("burst_timeout", 1'b1, 1'b0);
    bus.resp_i  = 1'b1;
    bus.burst_i = {$urandom, $urandom};
    chk("resp_o_done", bus.resp_o, 1'b1);
    chk("done_read_o", bus.read_o, 1'b0);
    chk("done_write_o", bus.write_o, 1'b0);
    if (!wr) begin
      exp_line = '0;
      foreach (got_beats[k]) exp_line = exp_line | ({192'd0, got_beats[k]} << (64 * k));
      chk("line_o", bus.line_o, exp_line);
      last_read = exp_line;
    end else begin
      chk("line_o_after_write", bus.line_o, last_read);
    end
    @(negedge clk);
    chk("idle_resp_o", bus.resp_o, 1'b0);
    chk("idle_read_o", bus.read_o, 1'b0);
    chk("idle_write_o", bus.write_o, 1'b0);
    chk("idle_line_o", bus.line_o, last_read);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{wr: 1'b0, both: 1'b0, addr: 32'h0000_1234,
                data: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                pat: 32'hF, pat_len: 4, exp_addr: 32'h0000_1220};
    vecs[1] = '{wr: 1'b1, both: 1'b0, addr: 32'h8000_0041,
                data: {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                       64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000},
                pat: 32'b1011001, pat_len: 7, exp_addr: 32'h8000_0040};
    vecs[2] = '{wr: 1'b1, both: 1'b1, addr: 32'h0000_00FF,
                data: {64'hAAAA_0000_0000_0003, 64'hBBBB_0000_0000_0002,
                       64'hCCCC_0000_0000_0001, 64'hDDDD_0000_0000_0000},
                pat: 32'b0110, pat_len: 4, exp_addr: 32'h0000_00E0};
    vecs[3] = '{wr: 1'b0, both: 1'b0, addr: 32'hFFFF_FFFF,
                data: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0},
                pat: 32'b0101_0011, pat_len: 8, exp_addr: 32'hFFFF_FFE0};

    last_read     = '0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_read", bus.read_o, 1'b0);
      chk("idle_no_write", bus.write_o, 1'b0);
    end

    for (int i = 0; i < 4; i++)
      run_txn(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].data,
              vecs[i].pat, vecs[i].pat_len, vecs[i].exp_addr);

    // Write leaves a nonzero latched line; reset mid-cycle must clear it at once.
    @(negedge clk);
    bus.write_i = 1'b1;
    bus.address_i = 32'h1357_9BDF;
    bus.line_i = {4{64'hCAFE_F00D_1234_5678}};
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_write");
    bus.write_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_read = '0;

    // Reset during beat 2 of a read: no resp_o, then a fresh read completes.
    @(negedge clk);
    bus.read_i = 1'b1;
    bus.address_i = 32'h0000_4000;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = {32'hBAD0_0000, b};
      @(negedge clk);
    end
    bus.burst_i = 64'hBAD0_0000_0000_0002;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_beat2");
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_read_o", bus.read_o, 1'b0);
      chk("post_rst_write_o", bus.write_o, 1'b0);
      chk("post_rst_resp_o", bus.resp_o, 1'b0);
    end
    run_txn(1'b0, 1'b0, 32'h0000_4010,
            {64'h7777_0000_0000_0003, 64'h6666_0000_0000_0002,
             64'h5555_0000_0000_0001, 64'h4444_0000_0000_0000},
            32'hF, 4, 32'h0000_4000);

    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      a = $urandom;
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              $urandom, 12, {a[31:5], 5'b0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
